// File: rtl/gaussian_pkg.sv
// rtl/gaussian_pkg.sv - shared constants and helpers for the KxK binomial filter
// Contents: LAT (input-to-output latency), coef() binomial taps, acc_width()
// accumulator width, shift_s() normalisation shift, ksize_legal() size check.
package gaussian_pkg;

  localparam int LAT = 3;

  function automatic int coef(input int ksize, input int i);
    if (ksize == 3) begin
      case (i)
        0, 2:    return 1;
        1:       return 2;
        default: return 0;
      endcase
    end else begin
      case (i)
        0, 4:    return 1;
        1, 3:    return 4;
        2:       return 6;
        default: return 0;
      endcase
    end
  endfunction

  // 2-D gain is 2^(2*(K-1)), so this width holds any full-scale window sum.
  function automatic int acc_width(input int data_width, input int ksize);
    return data_width + 2 * (ksize - 1);
  endfunction

  function automatic int shift_s(input int ksize);
    return 2 * (ksize - 1);
  endfunction

  function automatic bit ksize_legal(input int ksize);
    return (ksize == 3) || (ksize == 5);
  endfunction

endpackage

// File: rtl/gaussian_window_gen.sv
// rtl/gaussian_window_gen.sv - x/y counters, KSIZE-1 line buffers and KxK window registers
// Ports: clk, rst_n (async, active-low); pixel_in/pixel_valid/line_end/frame_end raster input;
// window_o flattened KxK window, element (r,c) at [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH],
// r=KSIZE-1 is the newest line and c=KSIZE-1 the newest column;
// win_valid_o/win_line_end_o/win_frame_end_o aligned with window_o.
module gaussian_window_gen
  import gaussian_pkg::*;
#(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int DATA_WIDTH = 8,
  parameter int KSIZE      = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_WIDTH-1:0]               pixel_in,
  input  logic                                pixel_valid,
  input  logic                                line_end,
  input  logic                                frame_end,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   window_o,
  output logic                                win_valid_o,
  output logic                                win_line_end_o,
  output logic                                win_frame_end_o
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // lb_mem[0] holds line y-1, lb_mem[i] holds line y-1-i; not reset.
  logic [DATA_WIDTH-1:0] lb_mem [KSIZE-1][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] col    [KSIZE];
  logic [DATA_WIDTH-1:0] win_q  [KSIZE][KSIZE];

  logic win_valid_d;
  logic win_valid_q, win_le_q, win_fe_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pixel_valid) begin
      if (frame_end) begin
        x_d = '0;
        y_d = '0;
      end else if (line_end) begin
        x_d = '0;
        if (y_q != YW'(IMG_HEIGHT - 1)) y_d = y_q + 1'b1;
      end else if (x_q != XW'(IMG_WIDTH - 1)) begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Vertical column for the current x: live pixel on the bottom row, older lines above.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) col[r] = '0;
    col[KSIZE-1] = pixel_in;
    for (int i = 0; i < KSIZE - 1; i++) col[KSIZE-2-i] = lb_mem[i][x_q];
  end

  // Each buffer cascades into the next older one at the same column.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb_mem[0][x_q] <= pixel_in;
      for (int i = 1; i < KSIZE - 1; i++) lb_mem[i][x_q] <= lb_mem[i-1][x_q];
    end
  end

  assign win_valid_d = pixel_valid && (x_q >= XW'(KSIZE - 1)) && (y_q >= YW'(KSIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < KSIZE; r++)
        for (int c = 0; c < KSIZE; c++) win_q[r][c] <= '0;
      win_valid_q <= 1'b0;
      win_le_q    <= 1'b0;
      win_fe_q    <= 1'b0;
    end else begin
      if (pixel_valid) begin
        for (int r = 0; r < KSIZE; r++) begin
          for (int c = 0; c < KSIZE - 1; c++) win_q[r][c] <= win_q[r][c+1];
          win_q[r][KSIZE-1] <= col[r];
        end
      end
      win_valid_q <= win_valid_d;
      win_le_q    <= win_valid_d && line_end;
      win_fe_q    <= win_valid_d && frame_end;
    end
  end

  always_comb begin
    window_o = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        window_o[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
  end

  assign win_valid_o     = win_valid_q;
  assign win_line_end_o  = win_le_q;
  assign win_frame_end_o = win_fe_q;

endmodule

// File: rtl/gaussian_filter_kxk.sv
// rtl/gaussian_filter_kxk.sv - streaming separable binomial filter, KSIZE 3 or 5, LAT=3
// Ports: clk, rst_n (async, active-low); pixel_in/pixel_valid/line_end/frame_end raster input;
// bypass (only with GAUSS_BYPASS_EN defined) selects the unfiltered centre pixel;
// pixel_out/pixel_valid_out/line_end_out/frame_end_out registered, aligned outputs.
// Optional build macro: GAUSS_BYPASS_EN.
module gaussian_filter_kxk
  import gaussian_pkg::*;
#(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int DATA_WIDTH = 8,
  parameter int KSIZE      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  line_end,
  input  logic                  frame_end,
`ifdef GAUSS_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid_out,
  output logic                  line_end_out,
  output logic                  frame_end_out
);

  localparam int ACC_W = acc_width(DATA_WIDTH, KSIZE);
  localparam int S     = shift_s(KSIZE);
  localparam int R     = (KSIZE - 1) / 2;

  if (!ksize_legal(KSIZE)) begin : g_bad_ksize
    $error("gaussian_filter_kxk: KSIZE must be 3 or 5");
  end

  logic [KSIZE*KSIZE*DATA_WIDTH-1:0] window;
  logic                              s1_valid, s1_le, s1_fe;
  logic [DATA_WIDTH-1:0]             win [KSIZE][KSIZE];

  // Stage 1 lives in the window generator.
  gaussian_window_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .DATA_WIDTH (DATA_WIDTH),
    .KSIZE      (KSIZE)
  ) u_window_gen (
    .clk             (clk),
    .rst_n           (rst_n),
    .pixel_in        (pixel_in),
    .pixel_valid     (pixel_valid),
    .line_end        (line_end),
    .frame_end       (frame_end),
    .window_o        (window),
    .win_valid_o     (s1_valid),
    .win_line_end_o  (s1_le),
    .win_frame_end_o (s1_fe)
  );

  always_comb begin
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        win[r][c] = window[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Stage 2: vertical sums per column.
  logic [ACC_W-1:0] vsum_d [KSIZE];
  logic [ACC_W-1:0] vsum_q [KSIZE];
  logic             s2_valid_q, s2_le_q, s2_fe_q;

  always_comb begin
    for (int c = 0; c < KSIZE; c++) begin
      vsum_d[c] = '0;
      for (int r = 0; r < KSIZE; r++)
        vsum_d[c] = vsum_d[c] + ACC_W'(coef(KSIZE, r)) * ACC_W'(win[r][c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < KSIZE; c++) vsum_q[c] <= '0;
      s2_valid_q <= 1'b0;
      s2_le_q    <= 1'b0;
      s2_fe_q    <= 1'b0;
    end else begin
      for (int c = 0; c < KSIZE; c++) vsum_q[c] <= vsum_d[c];
      s2_valid_q <= s1_valid;
      s2_le_q    <= s1_le;
      s2_fe_q    <= s1_fe;
    end
  end

  // Stage 3: horizontal sum, round half up, clamp.
  logic [ACC_W-1:0]      hsum, rounded;
  logic [DATA_WIDTH-1:0] filt;
  logic [DATA_WIDTH-1:0] out_d;

  always_comb begin
    hsum = '0;
    for (int c = 0; c < KSIZE; c++)
      hsum = hsum + ACC_W'(coef(KSIZE, c)) * vsum_q[c];
    // Full-scale sum plus the rounding half still fits ACC_W bits.
    rounded = (hsum + (ACC_W'(1) << (S - 1))) >> S;
    if (rounded > ACC_W'({DATA_WIDTH{1'b1}})) filt = '1;
    else                                      filt = rounded[DATA_WIDTH-1:0];
  end

`ifdef GAUSS_BYPASS_EN
  logic                  bp_s1_q, bp_s2_q;
  logic [DATA_WIDTH-1:0] centre_q;

  // bypass is captured with the pixel so it travels with that pixel's window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_s1_q  <= 1'b0;
      bp_s2_q  <= 1'b0;
      centre_q <= '0;
    end else begin
      if (pixel_valid) bp_s1_q <= bypass;
      bp_s2_q  <= bp_s1_q;
      centre_q <= win[R][R];
    end
  end

  always_comb begin
    out_d = filt;
    if (bp_s2_q) out_d = centre_q;
  end
`else
  always_comb begin
    out_d = filt;
  end
`endif

  logic [DATA_WIDTH-1:0] pixel_out_q;
  logic                  valid_out_q, le_out_q, fe_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out_q <= '0;
      valid_out_q <= 1'b0;
      le_out_q    <= 1'b0;
      fe_out_q    <= 1'b0;
    end else begin
      if (s2_valid_q) pixel_out_q <= out_d;
      valid_out_q <= s2_valid_q;
      le_out_q    <= s2_le_q;
      fe_out_q    <= s2_fe_q;
    end
  end

  assign pixel_out       = pixel_out_q;
  assign pixel_valid_out = valid_out_q;
  assign line_end_out    = le_out_q;
  assign frame_end_out   = fe_out_q;

endmodule
